spi_master: RTL and testbench

//  SPI initiator (single chip select) driving SCLK/MOSI/CS and sampling MISO; the controller-side

---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI initiator with a single chip select: all four CPOL/CPHA modes, MSB/LSB first,
// programmable SCLK divider and CS setup/hold/idle timing behind a start/done handshake.
module spi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_IDLE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned TOG_W   = $clog2(2 * DATA_WIDTH) + 1;
  localparam int unsigned IDX_W   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TIM_MAX = (CS_SETUP > CS_HOLD) ?
                                    ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                                    ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int unsigned TIM_W   = $clog2(TIM_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]            state,   state_n;
  logic [DIV_W-1:0]      div_cnt, div_cnt_n;
  logic [TOG_W-1:0]      tog_cnt, tog_cnt_n;
  logic [TIM_W-1:0]      tim_cnt, tim_cnt_n;
  logic [DATA_WIDTH-1:0] tx_word, tx_word_n;
  logic [DATA_WIDTH-1:0] rx_sr,   rx_sr_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  cpha_q,  cpha_q_n;
  logic                  lsb_q,   lsb_q_n;
  logic                  cpol_q,  cpol_q_n;
  logic                  busy_n, done_n, sclk_n, mosi_n, cs_n;

  logic [TOG_W-1:0]      tog_nx;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      bit_pos;
  logic                  lead;

  // Toggle number about to happen and the bit it selects in transmit order
  always_comb begin
    tog_nx  = tog_cnt + TOG_W'(1);
    lead    = tog_nx[0];
    bit_idx = IDX_W'(tog_nx >> 1);
    bit_pos = lsb_q ? bit_idx : (IDX_W'(DATA_WIDTH - 1) - bit_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      tog_cnt <= '0;
      tim_cnt <= '0;
      tx_word <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cpol_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      tog_cnt <= tog_cnt_n;
      tim_cnt <= tim_cnt_n;
      tx_word <= tx_word_n;
      rx_sr   <= rx_sr_n;
      rx_data <= rx_data_n;
      cpha_q  <= cpha_q_n;
      lsb_q   <= lsb_q_n;
      cpol_q  <= cpol_q_n;
      busy    <= busy_n;
      done    <= done_n;
      sclk    <= sclk_n;
      mosi    <= mosi_n;
      cs      <= cs_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    tog_cnt_n = tog_cnt;
    tim_cnt_n = tim_cnt;
    tx_word_n = tx_word;
    rx_sr_n   = rx_sr;
    rx_data_n = rx_data;
    cpha_q_n  = cpha_q;
    lsb_q_n   = lsb_q;
    cpol_q_n  = cpol_q;
    busy_n    = busy;
    done_n    = 1'b0;
    sclk_n    = sclk;
    mosi_n    = mosi;
    cs_n      = cs;

    case (state)
      S_IDLE: begin
        sclk_n = cpol;
        if (start) begin
          tx_word_n = tx_data;
          cpol_q_n  = cpol;
          cpha_q_n  = cpha;
          lsb_q_n   = lsb_first;
          cs_n      = 1'b0;
          busy_n    = 1'b1;
          mosi_n    = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
          div_cnt_n = '0;
          tog_cnt_n = '0;
          tim_cnt_n = '0;
          rx_sr_n   = '0;
          state_n   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (32'(tim_cnt) + 32'd1 == CS_SETUP) begin
          tim_cnt_n = '0;
          state_n   = S_XFER;
        end else begin
          tim_cnt_n = tim_cnt + TIM_W'(1);
        end
      end

      // Each divider wrap is one SCLK edge; odd toggles lead, even toggles trail
      S_XFER: begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_n = '0;
          sclk_n    = ~sclk;
          tog_cnt_n = tog_nx;
          if (lead != cpha_q) begin
            rx_sr_n = lsb_q ? {miso, rx_sr[DATA_WIDTH-1:1]}
                            : {rx_sr[DATA_WIDTH-2:0], miso};
          end else if (tog_nx != TOG_W'(2 * DATA_WIDTH)) begin
            mosi_n = tx_word[bit_pos];
          end
          if (tog_nx == TOG_W'(2 * DATA_WIDTH)) begin
            tim_cnt_n = '0;
            state_n   = S_HOLD;
          end
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (32'(tim_cnt) + 32'd1 == CS_HOLD) begin
          rx_data_n = rx_sr;
          done_n    = 1'b1;
          cs_n      = 1'b1;
          tim_cnt_n = '0;
          if (CS_IDLE > 1) begin
            state_n = S_GAP;
          end else begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end
        end else begin
          tim_cnt_n = tim_cnt + TIM_W'(1);
        end
      end

      // The done cycle counts as the first CS-high cycle, so IDLE can accept exactly CS_IDLE later
      S_GAP: begin
        if (32'(tim_cnt) + 32'd2 == CS_IDLE) begin
          tim_cnt_n = '0;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end else begin
          tim_cnt_n = tim_cnt + TIM_W'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        cs_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: event-level SPI target model on the bus, vector table plus random transfers.
module tb_spi_master;

  localparam int DW       = 8;
  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int XFER_CYC = CS_SETUP + 2 * DW * CLK_DIV + CS_HOLD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic          busy, done, sclk, mosi, miso, cs;
  logic [DW-1:0] rx_data;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
               .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Target model: counts SCLK edges while selected, samples/launches per CPHA and bit order
  logic [DW-1:0] sl_word = '0, sl_rx = '0;
  logic          sl_miso = 1'b0;
  logic          cur_cpha = 1'b0, cur_lsb = 1'b0, loopback = 1'b0;
  int            sl_edges = 0;
  bit            sl_lead;

  function automatic logic word_bit(input logic [DW-1:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[DW-1-i];
  endfunction

  assign miso = loopback ? mosi : sl_miso;

  always @(negedge cs) begin
    sl_edges = 0;
    sl_rx    = '0;
    sl_miso  = cur_cpha ? 1'b0 : word_bit(sl_word, 0, cur_lsb);
  end

  always @(sclk) begin
    if (cs === 1'b0 && rst === 1'b0) begin
      sl_edges++;
      sl_lead = (sl_edges % 2) == 1;
      if (sl_lead != cur_cpha)
        sl_rx = cur_lsb ? {mosi, sl_rx[DW-1:1]} : {sl_rx[DW-2:0], mosi};
      else if (sl_edges < 2 * DW)
        sl_miso = word_bit(sl_word, sl_edges / 2, cur_lsb);
    end
  end

  task automatic set_mode(input logic p, input logic h, input logic l, input logic [DW-1:0] tx,
                          input logic [DW-1:0] sw, input logic lb);
    @(negedge clk);
    cpol = p; cpha = h; lsb_first = l; tx_data = tx;
    cur_cpha = h; cur_lsb = l; sl_word = sw; loopback = lb;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_xfer(input logic p, input logic h, input logic l, input logic [DW-1:0] tx,
                          input logic [DW-1:0] sw, input logic lb, input logic disturb);
    int n = 0;
    int k, d0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", 32'(busy), 32'd0);
    set_mode(p, h, l, tx, sw, lb);
    start = 1'b1;
    k  = cyc + 1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cs_after_accept", 32'(cs), 32'd0);
    if (disturb) begin
      repeat (5) @(negedge clk);
      tx_data = ~tx; cpha = ~h; lsb_first = ~l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("xfer");
    chk("done_latency", 32'(cyc), 32'(k + XFER_CYC));
    chk("rx_data", 32'(rx_data), 32'(lb ? tx : sw));
    if (!lb) chk("target_rx", 32'(sl_rx), 32'(tx));
    chk("sclk_edges", 32'(sl_edges), 32'(2 * DW));
    chk("cs_at_done", 32'(cs), 32'd1);
    chk("sclk_idle_level", 32'(sclk), 32'(p));
    repeat (CS_IDLE + 2) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_released", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic          cpol, cpha, lsb;
    logic [DW-1:0] tx, sw;
    logic          loopb, disturb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, d0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h5A, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h96, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'hE7, 8'h18, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_xfer(vecs[i].cpol, vecs[i].cpha, vecs[i].lsb, vecs[i].tx, vecs[i].sw,
               vecs[i].loopb, vecs[i].disturb);

    // start held high: back-to-back transfers, CS high exactly CS_IDLE cycles
    set_mode(1'b0, 1'b0, 1'b0, 8'h6D, 8'h00, 1'b1);
    d0 = done_cnt;
    start = 1'b1;
    wait_done("b2b_first");
    n = 0;
    while (cs === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_cs_gap", 32'(n), 32'(CS_IDLE));
    @(negedge clk);
    wait_done("b2b_second");
    chk("b2b_rx_data", 32'(rx_data), 32'h6D);
    repeat (CS_IDLE + 2) @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset in the middle of the transfer
    set_mode(1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sl_edges < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_edge7", 32'(sl_edges), 32'd7);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(cs), 32'd1);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (XFER_CYC + 20) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_xfer(1'b0, 1'b1, 1'b0, 8'h4B, 8'hD2, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++)
      run_xfer(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               DW'($urandom), DW'($urandom), 1'b0, 1'($urandom_range(1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
